tetris_input_ctrl: RTL
======================

// Module: tetris_input_ctrl
// PURPOSE
//  Conditions the 8 JB controller buttons before the CPU reads them as register 27.
//  Per button: 2-FF synchroniser, debounce, press-edge capture into a pending latch,
//  and DAS/ARR auto-repeat for the movement buttons.
//  The CPU consumes one pending key per read of reg 27. Each read returns the highest-priority code.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000   stable cycles needed to accept a level change (10 ms @ 50 MHz)
//  DAS_CYCLES       8333333  held cycles before the first auto-repeat (~167 ms)
//  ARR_CYCLES       2500000  cycles between later auto-repeats (50 ms)
//  CNT_W            24       counter width; must hold max(DEBOUNCE,DAS,ARR)-1
//  REPEAT_MASK      8'h0E    buttons that auto-repeat (right, down, left)
// PORTS
//  clock        in   1   50 MHz system clock
//  reset        in   1   async, active-low; 0 = reset
//  btn_raw      in   8   async buttons {JB10,JB9,JB8,JB7,JB4,JB3,JB2,JB1}
//                        bit0 up, bit1 right, bit2 down, bit3 left, bit4 SL, bit5 SR, bit6 hold, bit7 reset-key
//  read_strobe  in   1   one-cycle pulse: CPU read reg 27 this cycle
//  key_valid    out  1   at least one pending key
//  key_word     out  32  {28'b0, code}; code in {1,2,3,4,7,8,9,10}; 0 when no key pending
//  held         out  8   debounced button levels (for LED indicators)
// BEHAVIOUR
//  Reset (reset=0, async): sync FFs, held, pending, all counters = 0; repeat FSMs = IDLE.
//    Outputs: key_valid=0, key_word=0, held=0.
//  Sync: 2 flops per bit; sync[i] = btn_raw[i] delayed 2 edges.
//  Debounce, per bit:
//    - cnt clears on any cycle where sync==held.
//    - cnt increments while sync!=held.
//    - At the edge where cnt==DEBOUNCE_CYCLES-1 and sync!=held: held<=sync, cnt<=0.
//    - Any bounce restarts the count.
//  Pending set: pending[i]<=1 on the edge held[i] goes 0->1. Falling edges set nothing.
//  Auto-repeat FSM, per bit with REPEAT_MASK[i]=1:
//    - IDLE:   held rises -> DELAY, rcnt=0.
//    - DELAY:  rcnt++; at rcnt==DAS_CYCLES-1 set pending[i], rcnt=0 -> REPEAT.
//    - REPEAT: rcnt++; at rcnt==ARR_CYCLES-1 set pending[i], rcnt=0, stay.
//    - held==0 in any state -> IDLE, rcnt=0, same edge.
//    - Bits with mask=0 stay in IDLE.
//  Output code is combinational from pending. Priority: bit7(10) > 6(9) > 5(8) > 4(7) > 3(4) > 2(3) > 1(2) > 0(1).
//  key_valid = |pending.
//  Consume: read_strobe && key_valid clears the pending bit currently shown, at that edge.
//    - read_strobe with key_valid=0: no effect.
//    - Set and clear of the same bit on one edge: set wins; key stays pending.
//    - Only one bit clears per strobe. Others persist; no queue depth beyond 1 per button.
//  A re-press before consume does not duplicate the key (pending is a latch).
//  Reset asserted mid-count or mid-repeat discards all state immediately.
// TESTING (bench params: DEBOUNCE=4, DAS=10, ARR=3)
//  1. Raise btn_raw[3] and hold -> held[3]=1 six edges after the raw change (2 sync + 4).
//     Same edge: key_valid=1, key_word=4.
//  2. Toggle btn_raw[1] 1/0 every 2 cycles for 20 cycles -> held[1] stays 0, key_valid stays 0.
//  3. Press bits 7 and 0 together, then pulse read_strobe twice ->
//     reads give 10 then 1; afterwards key_valid=0, key_word=0.
//  4. Hold bit2 with read_strobe every cycle ->
//     codes 3 at press, +10 cycles, then every 3 cycles.
//     Release -> no more codes; FSM returns to IDLE.
//  5. With bit3 in REPEAT, pulse read_strobe on the exact edge the ARR repeat sets pending[3]
//     -> key_valid remains 1 after that edge.
//  6. Pending keys plus bit2 in DELAY, drive reset=0 for 1 cycle (async) ->
//     key_valid=0, held=0 immediately; no repeat code after reset releases.

Source files
------------

// File: rtl/tetris_input_ctrl.sv
// Button conditioning for the JB controller: synchronise, debounce, latch presses,
// auto-repeat the movement keys and present the highest-priority pending key to the CPU.
module tetris_input_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          DAS_CYCLES      = 8333333,
    parameter int          ARR_CYCLES      = 2500000,
    parameter int          CNT_W           = 24,
    parameter logic [7:0]  REPEAT_MASK     = 8'h0E
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  btn_raw,
    input  logic        read_strobe,
    output logic        key_valid,
    output logic [31:0] key_word,
    output logic [7:0]  held
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);
    localparam logic [3:0]       CODE_LUT [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};

    logic [7:0]       sync1, sync2;
    logic [7:0]       held_next;
    logic [7:0]       pending, pending_next;
    logic [7:0]       fire;
    logic [7:0]       clear;
    logic [3:0]       code;
    logic [CNT_W-1:0] db_cnt [8];
    logic [CNT_W-1:0] db_cnt_next [8];
    logic [CNT_W-1:0] rcnt [8];
    logic [CNT_W-1:0] rcnt_next [8];
    rep_state_t       state [8];
    rep_state_t       state_next [8];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            held    <= '0;
            pending <= '0;
            for (int i = 0; i < 8; i++) begin
                db_cnt[i] <= '0;
                rcnt[i]   <= '0;
                state[i]  <= IDLE;
            end
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            held    <= held_next;
            pending <= pending_next;
            for (int i = 0; i < 8; i++) begin
                db_cnt[i] <= db_cnt_next[i];
                rcnt[i]   <= rcnt_next[i];
                state[i]  <= state_next[i];
            end
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        held_next = held;
        for (int i = 0; i < 8; i++) begin
            db_cnt_next[i] = '0;
            if (sync2[i] != held[i]) begin
                if (db_cnt[i] == DEB_LAST) begin
                    held_next[i] = sync2[i];
                end else begin
                    db_cnt_next[i] = db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press edges and auto-repeat ticks both raise fire; the FSM follows the new held level.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            state_next[i] = state[i];
            rcnt_next[i]  = '0;
            fire[i]       = held_next[i] & ~held[i];
            if (!REPEAT_MASK[i] || !held_next[i]) begin
                state_next[i] = IDLE;
            end else begin
                case (state[i])
                    IDLE: begin
                        if (fire[i]) state_next[i] = DELAY;
                    end
                    DELAY: begin
                        if (rcnt[i] == DAS_LAST) begin
                            fire[i]       = 1'b1;
                            state_next[i] = REPEAT;
                        end else begin
                            rcnt_next[i] = rcnt[i] + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (rcnt[i] == ARR_LAST) begin
                            fire[i] = 1'b1;
                        end else begin
                            rcnt_next[i] = rcnt[i] + CNT_W'(1);
                        end
                    end
                    default: state_next[i] = IDLE;
                endcase
            end
        end
    end

    // Ascending scan so the highest pending bit ends up selected.
    always_comb begin
        code  = 4'd0;
        clear = '0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) begin
                code     = CODE_LUT[i];
                clear    = '0;
                clear[i] = 1'b1;
            end
        end
        pending_next = (pending & ~((read_strobe && key_valid) ? clear : 8'h00)) | fire;
    end

    assign key_valid = |pending;
    assign key_word  = {28'b0, code};

endmodule
